coin_arbiter: RTL and testbench

Front-end controller that sequences coin events into the vending state machine. It synchronises and debounces the two raw coin inputs, then queues coin events. It issues them to the state machine as single-cycle, mutually exclusive have_coin5/have_coin10 pulses, with a guaranteed gap between pulses. While a vend is in progress (vend_busy, driven from the state machine's open), it rejects all incoming and queued coins and counts them for return.

---
 rtl/vend_pkg.sv | 20 ++
 rtl/coin_debounce.sv | 48 ++++
 rtl/coin_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_coin_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types and constants for the coin front-end
// Contents: coin_e (coin denomination tag stored in the event queue),
//           arb_state_e (issue sequencer states), REJECT_MAX (reject counter ceiling).
package vend_pkg;

    typedef enum logic {
        COIN5  = 1'b0,
        COIN10 = 1'b1
    } coin_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP,
        DRAIN
    } arb_state_e;

    localparam logic [7:0] REJECT_MAX = 8'd255;

endpackage

// File: rtl/coin_debounce.sv
// rtl/coin_debounce.sv - 2-FF synchroniser, stability debouncer and rising-edge detector
// Ports:
//   sys_clk    in  system clock
//   sys_rst_n  in  synchronous active-low reset
//   btn        in  raw asynchronous sensor input, active-high
//   rise       out one-cycle pulse when the debounced level goes 0 -> 1
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic btn,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            rise  <= 1'b0;
            // Any sample that agrees with the current level restarts the stability window.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= ~level;
                cnt   <= '0;
                rise  <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/coin_arbiter.sv
// rtl/coin_arbiter.sv - debounces coin sensors, queues coin events and issues spaced accept pulses
// Ports:
//   sys_clk       in   system clock
//   sys_rst_n     in   synchronous active-low reset
//   btn_coin5     in   raw 5-unit coin sensor
//   btn_coin10    in   raw 10-unit coin sensor
//   vend_busy     in   dispense in progress; coins are rejected while high
//   have_coin5    out  one-cycle pulse, 5-unit coin accepted
//   have_coin10   out  one-cycle pulse, 10-unit coin accepted
//   coin_reject   out  one-cycle pulse for any cycle rejecting at least one coin
//   reject_total  out  saturating count of rejected coins
//   pending       out  queue occupancy
module coin_arbiter
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int GAP_CYCLES      = 4,
    parameter int QUEUE_DEPTH     = 4
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic                         btn_coin5,
    input  logic                         btn_coin10,
    input  logic                         vend_busy,
    output logic                         have_coin5,
    output logic                         have_coin10,
    output logic                         coin_reject,
    output logic [7:0]                   reject_total,
    output logic [$clog2(QUEUE_DEPTH):0] pending
);

    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(QUEUE_DEPTH);
    localparam logic [AW:0]   ONE_C    = (AW + 1)'(1);
    localparam logic [AW:0]   TWO_C    = (AW + 1)'(2);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    logic          ev5;
    logic          ev10;
    coin_e         fifo [QUEUE_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] wr_ptr_p1;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   free_slots;
    logic          rr_first10;
    arb_state_e    state;
    arb_state_e    state_next;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_next;
    coin_e         head;
    coin_e         first_coin;
    coin_e         second_coin;
    logic [1:0]    n_push;
    logic [1:0]    n_ev_rej;
    logic [1:0]    n_rej;
    logic          rr_flip;
    logic          pop;
    logic          drain_rej;
    logic          issue5;
    logic          issue10;
    logic [8:0]    total_sum;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb5 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .btn       (btn_coin5),
        .rise      (ev5)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb10 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .btn       (btn_coin10),
        .rise      (ev10)
    );

    assign head      = fifo[rd_ptr];
    assign wr_ptr_p1 = wr_ptr + 1'b1;
    // Room is judged on occupancy before this cycle's pop, so a full queue never accepts.
    assign free_slots = DEPTH_C - pending;

    always_comb begin
        n_push      = 2'd0;
        n_ev_rej    = 2'd0;
        rr_flip     = 1'b0;
        first_coin  = COIN5;
        second_coin = COIN10;
        if (ev5 && ev10) begin
            first_coin  = rr_first10 ? COIN10 : COIN5;
            second_coin = rr_first10 ? COIN5 : COIN10;
            if (vend_busy) begin
                n_ev_rej = 2'd2;
            end else begin
                rr_flip = 1'b1;
                if (free_slots >= TWO_C) begin
                    n_push = 2'd2;
                end else if (free_slots == ONE_C) begin
                    n_push   = 2'd1;
                    n_ev_rej = 2'd1;
                end else begin
                    n_ev_rej = 2'd2;
                end
            end
        end else if (ev5 || ev10) begin
            first_coin = ev10 ? COIN10 : COIN5;
            if (vend_busy || free_slots == '0) begin
                n_ev_rej = 2'd1;
            end else begin
                n_push = 2'd1;
            end
        end
    end

    // Accept pulses are registered on entry to ISSUE so they coincide with the ISSUE state.
    always_comb begin
        state_next = state;
        gap_next   = gap_cnt;
        pop        = 1'b0;
        drain_rej  = 1'b0;
        issue5     = 1'b0;
        issue10    = 1'b0;
        case (state)
            IDLE: begin
                if (pending != '0) begin
                    if (vend_busy) begin
                        state_next = DRAIN;
                    end else begin
                        state_next = ISSUE;
                        issue5     = (head == COIN5);
                        issue10    = (head == COIN10);
                    end
                end
            end
            ISSUE: begin
                pop        = 1'b1;
                gap_next   = '0;
                state_next = GAP;
            end
            GAP: begin
                if (vend_busy && pending != '0) begin
                    state_next = DRAIN;
                end else if (gap_cnt == GAP_LAST) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap_cnt + 1'b1;
                end
            end
            DRAIN: begin
                pop       = (pending != '0);
                drain_rej = pop;
                if (n_push == 2'd0 && pending <= ONE_C) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign n_rej     = n_ev_rej + {1'b0, drain_rej};
    assign total_sum = {1'b0, reject_total} + {7'b0, n_rej};

    always_ff @(posedge sys_clk) begin
        if (n_push != 2'd0) begin
            fifo[wr_ptr] <= first_coin;
        end
        if (n_push == 2'd2) begin
            fifo[wr_ptr_p1] <= second_coin;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            gap_cnt      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            pending      <= '0;
            rr_first10   <= 1'b0;
            have_coin5   <= 1'b0;
            have_coin10  <= 1'b0;
            coin_reject  <= 1'b0;
            reject_total <= '0;
        end else begin
            state        <= state_next;
            gap_cnt      <= gap_next;
            wr_ptr       <= wr_ptr + AW'(n_push);
            rd_ptr       <= rd_ptr + AW'(pop);
            pending      <= pending + (AW + 1)'(n_push) - (AW + 1)'(pop);
            rr_first10   <= rr_first10 ^ rr_flip;
            have_coin5   <= issue5;
            have_coin10  <= issue10;
            coin_reject  <= (n_rej != 2'd0);
            reject_total <= total_sum[8] ? REJECT_MAX : total_sum[7:0];
        end
    end

endmodule

// File: tb/tb_coin_arbiter.sv
// tb/tb_coin_arbiter.sv - directed self-checking bench for coin_arbiter
module tb_coin_arbiter;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       btn_coin5 = 1'b0;
    logic       btn_coin10 = 1'b0;
    logic       vend_busy = 1'b0;
    logic       have_coin5;
    logic       have_coin10;
    logic       coin_reject;
    logic [7:0] reject_total;
    logic [2:0] pending;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int p_cyc[$];
    bit p_coin[$];
    int rej_pulses = 0;
    bit overlap = 1'b0;

    coin_arbiter #(
        .DEBOUNCE_CYCLES (4),
        .GAP_CYCLES      (4),
        .QUEUE_DEPTH     (4)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .btn_coin5    (btn_coin5),
        .btn_coin10   (btn_coin10),
        .vend_busy    (vend_busy),
        .have_coin5   (have_coin5),
        .have_coin10  (have_coin10),
        .coin_reject  (coin_reject),
        .reject_total (reject_total),
        .pending      (pending)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (have_coin5) begin
            p_cyc.push_back(cyc);
            p_coin.push_back(1'b0);
        end
        if (have_coin10) begin
            p_cyc.push_back(cyc);
            p_coin.push_back(1'b1);
        end
        if (have_coin5 && have_coin10) overlap = 1'b1;
        if (coin_reject) rej_pulses = rej_pulses + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        btn_coin5  = 1'b0;
        btn_coin10 = 1'b0;
        vend_busy  = 1'b0;
        sys_rst_n  = 1'b0;
        tick(2);
        sys_rst_n = 1'b1;
        tick(1);
        p_cyc.delete();
        p_coin.delete();
        rej_pulses = 0;
        overlap = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        tick(3);
        vectors++; if (have_coin5 !== 1'b0) begin miscompares++; $display("FAIL reset_have5: got %0b expected 0", have_coin5); end
        vectors++; if (have_coin10 !== 1'b0) begin miscompares++; $display("FAIL reset_have10: got %0b expected 0", have_coin10); end
        vectors++; if (coin_reject !== 1'b0) begin miscompares++; $display("FAIL reset_reject: got %0b expected 0", coin_reject); end
        vectors++; if (reject_total !== 8'd0) begin miscompares++; $display("FAIL reset_total: got %0d expected 0", reject_total); end
        vectors++; if (pending !== 3'd0) begin miscompares++; $display("FAIL reset_pending: got %0d expected 0", pending); end
        sys_rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_glitch();
        int c0;
        do_reset();
        c0 = cyc;
        for (int i = 0; i < 60; i++) begin
            btn_coin5  = (i < 20);
            btn_coin10 = (i < 20) && (i % 5 == 2);
            tick(1);
        end
        btn_coin10 = 1'b0;
        vectors++; if (p_cyc.size() != 1) begin miscompares++; $display("FAIL glitch_count: got %0d expected 1", p_cyc.size()); end
        else begin
            vectors++; if (p_coin[0] !== 1'b0) begin miscompares++; $display("FAIL glitch_coin: got %0d expected 0", p_coin[0]); end
            vectors++; if (p_cyc[0] != c0 + 8) begin miscompares++; $display("FAIL glitch_latency: got %0d expected %0d", p_cyc[0] - c0, 8); end
        end
        vectors++; if (reject_total !== 8'd0) begin miscompares++; $display("FAIL glitch_total: got %0d expected 0", reject_total); end
        vectors++; if (pending !== 3'd0) begin miscompares++; $display("FAIL glitch_pending: got %0d expected 0", pending); end
    endtask

    task automatic test_simultaneous();
        int c0;
        int exp_c[4] = '{8, 14, 48, 54};
        bit exp_k[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        c0 = cyc;
        for (int i = 0; i < 80; i++) begin
            btn_coin5  = (i < 10) || (i >= 40 && i < 50);
            btn_coin10 = btn_coin5;
            tick(1);
        end
        vectors++; if (p_cyc.size() != 4) begin miscompares++; $display("FAIL simul_count: got %0d expected 4", p_cyc.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
                vectors++; if (p_coin[k] !== exp_k[k]) begin miscompares++; $display("FAIL simul_coin%0d: got %0d expected %0d", k, p_coin[k], exp_k[k]); end
                vectors++; if (p_cyc[k] != c0 + exp_c[k]) begin miscompares++; $display("FAIL simul_cycle%0d: got %0d expected %0d", k, p_cyc[k] - c0, exp_c[k]); end
            end
        end
        vectors++; if (overlap !== 1'b0) begin miscompares++; $display("FAIL simul_overlap: got 1 expected 0"); end
    endtask

    task automatic test_overflow();
        int c0;
        bit exp_k[12] = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0};
        do_reset();
        c0 = cyc;
        for (int i = 0; i < 146; i++) begin
            btn_coin5  = (i < 56) && (i % 8 < 4);
            btn_coin10 = btn_coin5;
            tick(1);
        end
        vectors++; if (p_cyc.size() != 12) begin miscompares++; $display("FAIL ovf_count: got %0d expected 12", p_cyc.size()); end
        else begin
            for (int k = 0; k < 12; k++) begin
                vectors++; if (p_coin[k] !== exp_k[k]) begin miscompares++; $display("FAIL ovf_coin%0d: got %0d expected %0d", k, p_coin[k], exp_k[k]); end
                vectors++; if (p_cyc[k] != c0 + 8 + 6 * k) begin miscompares++; $display("FAIL ovf_cycle%0d: got %0d expected %0d", k, p_cyc[k] - c0, 8 + 6 * k); end
            end
        end
        vectors++; if (reject_total !== 8'd2) begin miscompares++; $display("FAIL ovf_total: got %0d expected 2", reject_total); end
        vectors++; if (rej_pulses != 2) begin miscompares++; $display("FAIL ovf_reject_pulses: got %0d expected 2", rej_pulses); end
        vectors++; if (pending !== 3'd0) begin miscompares++; $display("FAIL ovf_pending: got %0d expected 0", pending); end
        vectors++; if (overlap !== 1'b0) begin miscompares++; $display("FAIL ovf_overlap: got 1 expected 0"); end
    endtask

    task automatic test_drain();
        int c0;
        bit exp_k[3] = '{1'b0, 1'b1, 1'b1};
        do_reset();
        c0 = cyc;
        for (int i = 0; i < 80; i++) begin
            if (i == 23) begin
                vectors++; if (pending !== 3'd3) begin miscompares++; $display("FAIL drain_queued: got %0d expected 3", pending); end
            end
            if (i >= 24 && i <= 28) begin
                vectors++; if (coin_reject !== (i >= 25 && i <= 27)) begin miscompares++; $display("FAIL drain_reject_c%0d: got %0b expected %0b", i, coin_reject, (i >= 25 && i <= 27)); end
            end
            if (i == 27) begin
                vectors++; if (pending !== 3'd0) begin miscompares++; $display("FAIL drain_empty: got %0d expected 0", pending); end
            end
            btn_coin5  = (i < 24) && (i % 8 < 4);
            btn_coin10 = btn_coin5;
            vend_busy  = (i >= 23) && (i < 60);
            tick(1);
        end
        vectors++; if (p_cyc.size() != 3) begin miscompares++; $display("FAIL drain_issued: got %0d expected 3", p_cyc.size()); end
        else begin
            for (int k = 0; k < 3; k++) begin
                vectors++; if (p_coin[k] !== exp_k[k]) begin miscompares++; $display("FAIL drain_coin%0d: got %0d expected %0d", k, p_coin[k], exp_k[k]); end
            end
        end
        vectors++; if (reject_total !== 8'd3) begin miscompares++; $display("FAIL drain_total: got %0d expected 3", reject_total); end
        vectors++; if (rej_pulses != 3) begin miscompares++; $display("FAIL drain_reject_pulses: got %0d expected 3", rej_pulses); end
    endtask

    task automatic test_busy_reject();
        int c1;
        do_reset();
        vend_busy = 1'b1;
        for (int i = 0; i < 48; i++) begin
            btn_coin10 = (i % 16 < 6);
            tick(1);
        end
        btn_coin10 = 1'b0;
        vectors++; if (p_cyc.size() != 0) begin miscompares++; $display("FAIL busy_pulses: got %0d expected 0", p_cyc.size()); end
        vectors++; if (reject_total !== 8'd3) begin miscompares++; $display("FAIL busy_total: got %0d expected 3", reject_total); end
        vectors++; if (rej_pulses != 3) begin miscompares++; $display("FAIL busy_reject_pulses: got %0d expected 3", rej_pulses); end
        vend_busy = 1'b0;
        c1 = cyc;
        for (int i = 0; i < 30; i++) begin
            btn_coin5 = (i < 6);
            tick(1);
        end
        vectors++; if (p_cyc.size() != 1) begin miscompares++; $display("FAIL busy_after_count: got %0d expected 1", p_cyc.size()); end
        else begin
            vectors++; if (p_coin[0] !== 1'b0 || p_cyc[0] != c1 + 8) begin miscompares++; $display("FAIL busy_after_pulse: got coin %0d at %0d expected coin 0 at 8", p_coin[0], p_cyc[0] - c1); end
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            btn_coin5  = (i < 4);
            btn_coin10 = btn_coin5;
            tick(1);
        end
        vectors++; if (pending !== 3'd2) begin miscompares++; $display("FAIL midrst_queued: got %0d expected 2", pending); end
        sys_rst_n = 1'b0;
        tick(1);
        vectors++; if (pending !== 3'd0) begin miscompares++; $display("FAIL midrst_pending: got %0d expected 0", pending); end
        vectors++; if (have_coin5 !== 1'b0 || have_coin10 !== 1'b0) begin miscompares++; $display("FAIL midrst_have: got %0b%0b expected 00", have_coin5, have_coin10); end
        vectors++; if (coin_reject !== 1'b0 || reject_total !== 8'd0) begin miscompares++; $display("FAIL midrst_reject: got %0b/%0d expected 0/0", coin_reject, reject_total); end
        sys_rst_n = 1'b1;
        tick(20);
        vectors++; if (p_cyc.size() != 0) begin miscompares++; $display("FAIL midrst_no_issue: got %0d expected 0", p_cyc.size()); end
    endtask

    task automatic burst_both(input int n);
        for (int b = 0; b < n; b++) begin
            for (int i = 0; i < 8; i++) begin
                btn_coin5  = (i < 4);
                btn_coin10 = btn_coin5;
                tick(1);
            end
        end
        tick(4);
    endtask

    task automatic test_saturate();
        do_reset();
        vend_busy = 1'b1;
        burst_both(127);
        vectors++; if (reject_total !== 8'd254) begin miscompares++; $display("FAIL sat_254: got %0d expected 254", reject_total); end
        burst_both(1);
        vectors++; if (reject_total !== 8'd255) begin miscompares++; $display("FAIL sat_clip: got %0d expected 255", reject_total); end
        burst_both(22);
        vectors++; if (reject_total !== 8'd255) begin miscompares++; $display("FAIL sat_hold: got %0d expected 255", reject_total); end
        vectors++; if (p_cyc.size() != 0) begin miscompares++; $display("FAIL sat_pulses: got %0d expected 0", p_cyc.size()); end
        vend_busy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_simultaneous();
        test_overflow();
        test_drain();
        test_busy_reject();
        test_reset_midop();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
